// File: rtl/bus_arbiter_pkg.sv
// ---------------------------------------------------------------------------
// bus_arbiter_pkg
// Shared definitions for the two-master system-bus arbiter:
//   - arb_state_t            : arbiter FSM state encoding
//   - M1 / M2                : master identifiers (also the bus_sel encoding)
//   - DEFAULT_TIMEOUT_CYCLES : default grant watchdog limit
// ---------------------------------------------------------------------------
package bus_arbiter_pkg;

   typedef enum logic [1:0] {
      IDLE   = 2'd0,
      GNT_M1 = 2'd1,
      GNT_M2 = 2'd2,
      TURN   = 2'd3
   } arb_state_t;

   localparam logic M1 = 1'b0;
   localparam logic M2 = 1'b1;

   localparam int DEFAULT_TIMEOUT_CYCLES = 1024;

endpackage : bus_arbiter_pkg

// File: rtl/bus_arbiter_watchdog.sv
// ---------------------------------------------------------------------------
// arb_watchdog
// Grant-hold watchdog: a clearable, enabled up-counter with a terminal-count
// flag at TIMEOUT_CYCLES-1.
// Ports:
//   clk      : system clock
//   reset    : synchronous, active-high reset (counter to 0)
//   i_clear  : synchronous clear (held while no grant is active)
//   i_en     : count enable (high while a grant is active)
//   o_tc     : terminal count reached (counter == TIMEOUT_CYCLES-1)
// ---------------------------------------------------------------------------
module arb_watchdog
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES
) (
   input  logic clk,
   input  logic reset,
   input  logic i_clear,
   input  logic i_en,
   output logic o_tc
);

   localparam int CNT_W = (TIMEOUT_CYCLES > 1) ? $clog2(TIMEOUT_CYCLES) : 1;
   localparam logic [CNT_W-1:0] TC_VAL = CNT_W'(TIMEOUT_CYCLES - 1);

   logic [CNT_W-1:0] r_cnt;

   // Counting stops at terminal count; the arbiter releases the grant there,
   // so the counter never wraps.
   always_ff @(posedge clk) begin
      if (reset || i_clear) begin
         r_cnt <= '0;
      end else if (i_en && !o_tc) begin
         r_cnt <= r_cnt + CNT_W'(1);
      end
   end

   assign o_tc = (r_cnt == TC_VAL);

endmodule : arb_watchdog

// File: rtl/bus_arbiter.sv
// ---------------------------------------------------------------------------
// bus_arbiter
// Two-master arbiter for the shared system bus. One master owns the bus for
// a whole transaction (including bursts) until xfer_done, the owner drops
// its request, or the grant watchdog expires. Each release is followed by a
// one-cycle turnaround with no grant.
// Ports:
//   clk, reset  : system clock, synchronous active-high reset
//   req_m1/m2   : master requests, held for the whole transaction
//   xfer_done   : one-cycle completion pulse from the slave side
//   grant_m1/m2 : registered grants (never both high)
//   bus_sel     : mux select (0 = m1, 1 = m2), holds last owner when idle
//   bus_busy    : high while either grant is active
//   timeout_err : one-cycle pulse when the watchdog forces a release
//   last_owner  : owner of the most recently ended grant
// ---------------------------------------------------------------------------
module bus_arbiter
   import bus_arbiter_pkg::*;
#(
   parameter int TIMEOUT_CYCLES = DEFAULT_TIMEOUT_CYCLES,
   parameter bit FIXED_PRIO     = 1'b0
) (
   input  logic clk,
   input  logic reset,
   input  logic req_m1,
   input  logic req_m2,
   input  logic xfer_done,
   output logic grant_m1,
   output logic grant_m2,
   output logic bus_sel,
   output logic bus_busy,
   output logic timeout_err,
   output logic last_owner
);

   arb_state_t r_state;

   logic w_in_grant;
   logic w_owner;
   logic w_own_req;
   logic w_tie_winner;
   logic w_tc;
   logic w_release;

   assign w_in_grant = (r_state == GNT_M1) || (r_state == GNT_M2);
   assign w_owner    = (r_state == GNT_M2) ? M2 : M1;
   assign w_own_req  = (r_state == GNT_M2) ? req_m2 : req_m1;

   // Round-robin hands a tie to the master that did not own the bus last.
   assign w_tie_winner = FIXED_PRIO ? M1 : ~last_owner;

   assign w_release = xfer_done || !w_own_req || w_tc;

   arb_watchdog #(
      .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
   ) u_watchdog (
      .clk     (clk),
      .reset   (reset),
      .i_clear (!w_in_grant),
      .i_en    (w_in_grant),
      .o_tc    (w_tc)
   );

   always_ff @(posedge clk) begin
      if (reset) begin
         r_state     <= IDLE;
         grant_m1    <= 1'b0;
         grant_m2    <= 1'b0;
         bus_sel     <= M1;
         bus_busy    <= 1'b0;
         timeout_err <= 1'b0;
         last_owner  <= M2;
      end else begin
         timeout_err <= 1'b0;
         case (r_state)
            IDLE: begin
               if (req_m1 && (!req_m2 || (w_tie_winner == M1))) begin
                  r_state  <= GNT_M1;
                  grant_m1 <= 1'b1;
                  bus_sel  <= M1;
                  bus_busy <= 1'b1;
               end else if (req_m2) begin
                  r_state  <= GNT_M2;
                  grant_m2 <= 1'b1;
                  bus_sel  <= M2;
                  bus_busy <= 1'b1;
               end
            end
            GNT_M1, GNT_M2: begin
               if (w_release) begin
                  r_state     <= TURN;
                  grant_m1    <= 1'b0;
                  grant_m2    <= 1'b0;
                  bus_busy    <= 1'b0;
                  last_owner  <= w_owner;
                  // Only a pure watchdog expiry is an error; completion or
                  // abort in the same cycle takes precedence.
                  timeout_err <= !xfer_done && w_own_req && w_tc;
               end
            end
            TURN: begin
               r_state <= IDLE;
            end
            default: begin
               r_state <= IDLE;
            end
         endcase
      end
   end

endmodule : bus_arbiter

// File: tb/tb_bus_arbiter.sv
// ---------------------------------------------------------------------------
// tb_bus_arbiter
// Directed bench for bus_arbiter. dut_a: round-robin, TIMEOUT_CYCLES=8.
// dut_b: fixed priority, TIMEOUT_CYCLES=32.
// ---------------------------------------------------------------------------
module tb_bus_arbiter;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic a_rst, a_r1, a_r2, a_done;
   logic a_g1, a_g2, a_sel, a_busy, a_terr, a_last;
   logic b_rst, b_r1, b_r2, b_done;
   logic b_g1, b_g2, b_sel, b_busy, b_terr, b_last;

   bus_arbiter #(.TIMEOUT_CYCLES(8), .FIXED_PRIO(1'b0)) dut_a (
      .clk(clk), .reset(a_rst), .req_m1(a_r1), .req_m2(a_r2), .xfer_done(a_done),
      .grant_m1(a_g1), .grant_m2(a_g2), .bus_sel(a_sel), .bus_busy(a_busy),
      .timeout_err(a_terr), .last_owner(a_last)
   );

   bus_arbiter #(.TIMEOUT_CYCLES(32), .FIXED_PRIO(1'b1)) dut_b (
      .clk(clk), .reset(b_rst), .req_m1(b_r1), .req_m2(b_r2), .xfer_done(b_done),
      .grant_m1(b_g1), .grant_m2(b_g2), .bus_sel(b_sel), .bus_busy(b_busy),
      .timeout_err(b_terr), .last_owner(b_last)
   );

   int checks = 0;
   int errors = 0;
   int overlaps = 0;

   // Output vector order: {grant_m1, grant_m2, bus_sel, bus_busy, timeout_err, last_owner}
   typedef struct {
      logic       r1;
      logic       r2;
      logic       d;
      logic [5:0] exp;
   } vec_t;

   vec_t tbl [24];

   function automatic logic [5:0] a_out();
      return {a_g1, a_g2, a_sel, a_busy, a_terr, a_last};
   endfunction

   function automatic logic [5:0] b_out();
      return {b_g1, b_g2, b_sel, b_busy, b_terr, b_last};
   endfunction

   task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
      checks++;
      if (act !== exp) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   always @(negedge clk) begin
      if ((a_g1 && a_g2) || (b_g1 && b_g2)) overlaps++;
   end

   initial begin
      int gcnt, tcnt, tidx, rises;
      logic prev_g1;

      tbl[0]  = '{1'b0, 1'b0, 1'b0, 6'b000001};
      tbl[1]  = '{1'b1, 1'b1, 1'b0, 6'b100101};
      tbl[2]  = '{1'b1, 1'b1, 1'b0, 6'b100101};
      tbl[3]  = '{1'b1, 1'b1, 1'b1, 6'b000000};
      tbl[4]  = '{1'b1, 1'b1, 1'b0, 6'b000000};
      tbl[5]  = '{1'b1, 1'b1, 1'b0, 6'b011100};
      tbl[6]  = '{1'b1, 1'b1, 1'b0, 6'b011100};
      tbl[7]  = '{1'b1, 1'b0, 1'b0, 6'b001001};
      tbl[8]  = '{1'b1, 1'b0, 1'b0, 6'b001001};
      tbl[9]  = '{1'b1, 1'b0, 1'b0, 6'b100101};
      tbl[10] = '{1'b0, 1'b1, 1'b1, 6'b000000};
      tbl[11] = '{1'b0, 1'b1, 1'b1, 6'b000000};
      tbl[12] = '{1'b0, 1'b1, 1'b1, 6'b011100};
      tbl[13] = '{1'b0, 1'b1, 1'b0, 6'b011100};
      tbl[14] = '{1'b0, 1'b0, 1'b0, 6'b001001};
      tbl[15] = '{1'b0, 1'b0, 1'b0, 6'b001001};
      tbl[16] = '{1'b0, 1'b0, 1'b1, 6'b001001};
      tbl[17] = '{1'b0, 1'b1, 1'b0, 6'b011101};
      tbl[18] = '{1'b1, 1'b1, 1'b0, 6'b011101};
      tbl[19] = '{1'b1, 1'b1, 1'b1, 6'b001001};
      tbl[20] = '{1'b1, 1'b1, 1'b0, 6'b001001};
      tbl[21] = '{1'b1, 1'b1, 1'b0, 6'b100101};
      tbl[22] = '{1'b0, 1'b0, 1'b0, 6'b000000};
      tbl[23] = '{1'b0, 1'b0, 1'b0, 6'b000000};

      a_rst = 1'b1; a_r1 = 1'b0; a_r2 = 1'b0; a_done = 1'b0;
      b_rst = 1'b1; b_r1 = 1'b0; b_r2 = 1'b0; b_done = 1'b0;
      step();
      step();
      check("reset_a", a_out(), 6'b000001);
      check("reset_b", b_out(), 6'b000001);
      a_rst = 1'b0;
      b_rst = 1'b0;

      // Table: one cycle per row on the round-robin arbiter.
      for (int i = 0; i < 24; i++) begin
         a_r1 = tbl[i].r1; a_r2 = tbl[i].r2; a_done = tbl[i].d;
         step();
         check($sformatf("vec%0d", i), a_out(), tbl[i].exp);
      end
      a_r1 = 1'b0; a_r2 = 1'b0; a_done = 1'b0;

      // Watchdog expiry: grant held 8 cycles, single error pulse on release.
      a_r2 = 1'b1;
      gcnt = 0; tcnt = 0; tidx = -1;
      for (int i = 0; i < 10; i++) begin
         step();
         if (a_g2) gcnt++;
         if (a_terr) begin
            tcnt++;
            tidx = i;
            check("timeout_release_out", a_out(), 6'b001011);
         end
      end
      a_r2 = 1'b0;
      check("timeout_grant_cycles", gcnt, 8);
      check("timeout_err_pulses", tcnt, 1);
      check("timeout_err_cycle", tidx, 8);
      step();
      step();

      // xfer_done on the terminal-count cycle: clean release, no error.
      a_r2 = 1'b1;
      for (int i = 0; i < 8; i++) step();
      check("tc_done_pre", a_out(), 6'b011101);
      a_done = 1'b1;
      step();
      a_done = 1'b0;
      check("tc_done_release", a_out(), 6'b001001);
      a_r2 = 1'b0;
      step();
      check("tc_done_no_late_err", a_terr, 1'b0);
      step();

      // Reset in the middle of an m2 grant.
      a_r1 = 1'b1;
      step();
      a_done = 1'b1;
      step();
      a_done = 1'b0; a_r1 = 1'b0;
      check("pre_reset_last_m1", a_last, 1'b0);
      step();
      a_r2 = 1'b1;
      step();
      step();
      check("pre_reset_grant_m2", a_out(), 6'b011100);
      a_rst = 1'b1;
      step();
      check("reset_mid_grant", a_out(), 6'b000001);
      a_rst = 1'b0; a_r2 = 1'b0;
      step();
      check("after_reset_idle", a_out(), 6'b000001);

      // Fixed priority: both requesting, done every 10 cycles, m2 starves.
      b_r1 = 1'b1; b_r2 = 1'b1;
      gcnt = 0; rises = 0; prev_g1 = 1'b0;
      for (int i = 0; i < 40; i++) begin
         b_done = (i % 10 == 9);
         step();
         if (b_g2) gcnt++;
         if (b_g1 && !prev_g1) rises++;
         prev_g1 = b_g1;
      end
      b_done = 1'b0; b_r1 = 1'b0; b_r2 = 1'b0;
      check("fixed_prio_m2_starved", gcnt, 0);
      check("fixed_prio_m1_grants", rises, 4);
      check("fixed_prio_last_owner", b_last, 1'b0);

      check("grant_overlap_cycles", overlaps, 0);

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule : tb_bus_arbiter

// File: doc/bus_arbiter.md
Name: bus_arbiter

Overview:
Two-master arbiter for the shared system bus. It grants exactly one master (m1 or m2) ownership of the address/data/control path at a time. Ownership is held for the whole transaction, including bursts, until the slave side signals completion, the master withdraws, or a watchdog expires. It sits between the master-side request logic (command processors) and the bus mux/slave-select path, and drives the mux select.

Parameters:
TIMEOUT_CYCLES, 1024, max cycles a grant may be held before forced release (>=2)
FIXED_PRIO, 0, 0 = round-robin between masters; 1 = m1 always wins ties

Ports:
clk  input  1  system clock
reset  input  1  synchronous, active-high reset
req_m1  input  1  m1 requests bus; held high for the duration of its transaction
req_m2  input  1  m2 requests bus; same rules
xfer_done  input  1  one-cycle pulse from slave side: current transaction (all burst beats) finished
grant_m1  output  1  m1 owns bus (registered)
grant_m2  output  1  m2 owns bus (registered)
bus_sel  output  1  mux select, 0 = m1, 1 = m2; holds last owner when idle
bus_busy  output  1  high while any grant is active
timeout_err  output  1  one-cycle pulse when watchdog forces release
last_owner  output  1  owner of most recent completed or aborted grant (0 = m1, 1 = m2)

Behaviour:
- Reset (sync, active-high): state=IDLE; grant_m1=grant_m2=0, bus_sel=0, bus_busy=0, timeout_err=0, last_owner=1 (so m1 wins the first tie under round-robin); watchdog counter=0. Reset mid-grant drops the grant on the next edge, with no error pulse.
- States: IDLE, GNT_M1, GNT_M2, TURN (one-cycle turnaround, all grants low).
- IDLE: if only req_mX is high -> GNT_mX. If both are high: FIXED_PRIO=1 -> GNT_M1; FIXED_PRIO=0 -> grant the master that is not last_owner. If neither -> stay.
- Latency: req rising in IDLE at cycle N -> grant high at N+1. bus_sel updates in the same cycle as the grant. bus_busy = grant_m1 | grant_m2.
- GNT_mX exit conditions, evaluated each cycle in priority order:
  1) xfer_done=1 -> TURN, normal completion.
  2) req_mX=0 -> TURN, master abort, no error.
  3) watchdog == TIMEOUT_CYCLES-1 -> TURN, timeout_err=1 for one cycle.
  On any exit, last_owner <= X.
- Simultaneous xfer_done and timeout: done wins, no timeout_err.
- Watchdog: cleared on grant entry, increments each cycle in GNT_mX, width $clog2(TIMEOUT_CYCLES). It never wraps because release occurs at terminal count.
- TURN: grants low for exactly one cycle, then IDLE. Earliest re-grant is 2 cycles after the exit condition.
- xfer_done while in IDLE or TURN is ignored.
- The other master's req does not pre-empt the current grant.
- Invariant: grant_m1 & grant_m2 is never 1.

Decomposition:
- Shared bus package: state encoding (IDLE=2'd0, GNT_M1=2'd1, GNT_M2=2'd2, TURN=2'd3), master IDs (M1=1'b0, M2=1'b1), default TIMEOUT_CYCLES.
- One natural sub-module: arb_watchdog (load/enable counter with terminal-count flag, parameterised by TIMEOUT_CYCLES). Everything else lives in bus_arbiter.

Test Plan:
- Single requester: req_m1=1 at cycle 5 -> grant_m1=1, bus_sel=0, bus_busy=1 at cycle 6. xfer_done pulse at cycle 20 -> grant_m1=0 at 21, IDLE at 22, last_owner=0.
- Tie under round-robin: after reset, req_m1=req_m2=1 held -> m1 granted. After m1's done, m2 granted 2 cycles later. Grants keep alternating; no cycle has both grants high.
- FIXED_PRIO=1: both requesting continuously, done every 10 cycles -> m1 granted every time and m2 starves.
- Timeout (TIMEOUT_CYCLES=8): req_m2 held, no done -> grant_m2 high for exactly 8 cycles, timeout_err pulses once on the release edge, then TURN.
- Boundary cases:
  - xfer_done coincident with terminal count -> release with timeout_err=0.
  - req_m1 dropped mid-grant -> release with no error.
  - reset asserted mid-grant -> all outputs return to reset values next cycle, last_owner=1.
